// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - command handshake between move_scheduler and tetris_game
interface move_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - merges key, auto-shift, soft-drop and gravity requests into one command port
module move_scheduler #(
  parameter int DAS_DELAY = 10,
  parameter int DAS_RATE  = 3,
  parameter int SOFT_RATE = 2,
  parameter int GRAV_BASE = 48,
  parameter int GRAV_STEP = 3,
  parameter int GRAV_MIN  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_game,
  input  logic             enable,
  input  logic [3:0]       level,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_down,
  input  logic             key_rotate,
  input  logic             key_drop,
  move_scheduler_if.master cmd,
  output logic             das_active
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_SOFT  = 3'd3;
  localparam logic [2:0] OP_GRAV  = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;
  localparam logic [2:0] OP_HARD  = 3'd6;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // das_cnt parks at DAS_FIRST once repeating, so each repeat fires at DAS_NEXT
  localparam logic [7:0] DAS_FIRST = 8'(DAS_DELAY);
  localparam logic [7:0] DAS_NEXT  = 8'(DAS_DELAY + DAS_RATE);
  localparam logic [7:0] SOFT_LAST = 8'(SOFT_RATE);
  localparam logic [6:0] BASE7     = 7'(GRAV_BASE);
  localparam logic [6:0] STEP7     = 7'(GRAV_STEP);
  localparam logic [6:0] MIN7      = 7'(GRAV_MIN);

  logic [0:0] state;
  logic [2:0] op_q;
  logic [4:0] key_q;
  logic       rise_left, rise_right, rise_down, rise_rot, rise_drop;
  logic       pend_left, pend_right, pend_soft, pend_grav, pend_rot, pend_hard;
  logic       ev_left, ev_right, ev_soft, ev_grav, ev_rot, ev_hard;
  logic [7:0] das_cnt, das_cnt_nxt;
  logic       das_active_nxt;
  logic [7:0] soft_cnt, soft_cnt_nxt;
  logic [6:0] grav_cnt, grav_cnt_nxt;
  logic [6:0] grav_drop, period;
  logic       accept, clr_grav, clr_by_hard;
  logic       any_pend;
  logic [2:0] pick;

  assign rise_left  = key_left   & ~key_q[0];
  assign rise_right = key_right  & ~key_q[1];
  assign rise_down  = key_down   & ~key_q[2];
  assign rise_rot   = key_rotate & ~key_q[3];
  assign rise_drop  = key_drop   & ~key_q[4];

  // Gravity period shrinks with level; the 8-bit compare keeps the saturation test from wrapping
  assign grav_drop = 7'(level) * STEP7;
  assign period    = (({1'b0, grav_drop} + {1'b0, MIN7}) > {1'b0, BASE7}) ? MIN7 : (BASE7 - grav_drop);

  assign accept      = (state == ST_ISSUE) & cmd.cmd_ready;
  assign clr_by_hard = accept & (op_q == OP_HARD);
  assign clr_grav    = accept & ((op_q == OP_SOFT) | (op_q == OP_HARD));

  assign cmd.cmd_valid = (state == ST_ISSUE);
  assign cmd.cmd_op    = op_q;

  // Event generation and next counter values; everything idles at zero while disabled
  always_comb begin
    ev_left        = 1'b0;
    ev_right       = 1'b0;
    ev_soft        = 1'b0;
    ev_grav        = 1'b0;
    ev_rot         = 1'b0;
    ev_hard        = 1'b0;
    das_cnt_nxt    = 8'd0;
    das_active_nxt = 1'b0;
    soft_cnt_nxt   = 8'd0;
    grav_cnt_nxt   = 7'd0;
    if (enable) begin
      ev_left  = rise_left;
      ev_right = rise_right;
      ev_soft  = rise_down;
      ev_rot   = rise_rot;
      ev_hard  = rise_drop;

      // A fresh left/right press restarts the delay; conflicting or released keys stop repeating
      if (!(rise_left | rise_right) && (key_left ^ key_right)) begin
        das_cnt_nxt    = das_cnt;
        das_active_nxt = das_active;
        if (tick_game) begin
          if ((!das_active && (das_cnt + 8'd1 == DAS_FIRST)) ||
              (das_active && (das_cnt + 8'd1 == DAS_NEXT))) begin
            das_cnt_nxt    = DAS_FIRST;
            das_active_nxt = 1'b1;
            if (key_left) ev_left = 1'b1;
            else          ev_right = 1'b1;
          end else begin
            das_cnt_nxt = das_cnt + 8'd1;
          end
        end
      end

      if (!rise_down && key_down) begin
        soft_cnt_nxt = soft_cnt;
        if (tick_game) begin
          if (soft_cnt + 8'd1 == SOFT_LAST) begin
            soft_cnt_nxt = 8'd0;
            ev_soft      = 1'b1;
          end else begin
            soft_cnt_nxt = soft_cnt + 8'd1;
          end
        end
      end

      // >= lets a freshly shortened period fire on the very next tick
      grav_cnt_nxt = grav_cnt;
      if (tick_game) begin
        if (grav_cnt + 7'd1 >= period) begin
          grav_cnt_nxt = 7'd0;
          ev_grav      = 1'b1;
        end else begin
          grav_cnt_nxt = grav_cnt + 7'd1;
        end
      end
    end
  end

  // Fixed priority: HARD > ROT > LEFT > RIGHT > SOFT > GRAV
  always_comb begin
    any_pend = pend_left | pend_right | pend_soft | pend_grav | pend_rot | pend_hard;
    pick     = OP_NONE;
    if (pend_hard)       pick = OP_HARD;
    else if (pend_rot)   pick = OP_ROT;
    else if (pend_left)  pick = OP_LEFT;
    else if (pend_right) pick = OP_RIGHT;
    else if (pend_soft)  pick = OP_SOFT;
    else if (pend_grav)  pick = OP_GRAV;
  end

  // Registered key copies for edge detection; updated even while disabled so held keys never re-edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= 5'd0;
    else        key_q <= {key_drop, key_rotate, key_down, key_right, key_left};
  end

  // Repeat and gravity counters; SOFT or HARD acceptance restarts the gravity period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      das_cnt    <= 8'd0;
      das_active <= 1'b0;
      soft_cnt   <= 8'd0;
      grav_cnt   <= 7'd0;
    end else begin
      das_cnt    <= das_cnt_nxt;
      das_active <= das_active_nxt;
      soft_cnt   <= soft_cnt_nxt;
      grav_cnt   <= clr_grav ? 7'd0 : grav_cnt_nxt;
    end
  end

  // Pending bits coalesce events; a same-cycle event beats the acceptance clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_soft  <= 1'b0;
      pend_grav  <= 1'b0;
      pend_rot   <= 1'b0;
      pend_hard  <= 1'b0;
    end else begin
      pend_left  <= enable & ((pend_left  & ~(accept & (op_q == OP_LEFT)))  | ev_left);
      pend_right <= enable & ((pend_right & ~(accept & (op_q == OP_RIGHT))) | ev_right);
      pend_soft  <= enable & ((pend_soft  & ~(accept & (op_q == OP_SOFT)) & ~clr_by_hard) | ev_soft);
      pend_grav  <= enable & ((pend_grav  & ~(accept & (op_q == OP_GRAV)) & ~clr_by_hard) | ev_grav);
      pend_rot   <= enable & ((pend_rot   & ~(accept & (op_q == OP_ROT)))   | ev_rot);
      pend_hard  <= enable & ((pend_hard  & ~accept_hard_only())            | ev_hard);
    end
  end

  function automatic logic accept_hard_only();
    return clr_by_hard;
  endfunction

  // Issue FSM: offer one op, hold it stable until accepted, then return to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= OP_NONE;
    end else if (state == ST_IDLE) begin
      if (enable && any_pend) begin
        state <= ST_ISSUE;
        op_q  <= pick;
      end
    end else if (cmd.cmd_ready) begin
      state <= ST_IDLE;
      op_q  <= OP_NONE;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler
module tb_move_scheduler;

  localparam int OP_LEFT = 1, OP_RIGHT = 2, OP_SOFT = 3, OP_GRAV = 4, OP_ROT = 5, OP_HARD = 6;
  localparam int DAS_DELAY = 10, DAS_RATE = 3, SOFT_RATE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_game = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] level = 4'd0;
  logic       key_left = 1'b0, key_right = 1'b0, key_down = 1'b0, key_rotate = 1'b0, key_drop = 1'b0;
  logic       das_active;

  move_scheduler_if cmd_bus();

  move_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_game  (tick_game),
    .enable     (enable),
    .level      (level),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .key_drop   (key_drop),
    .cmd        (cmd_bus),
    .das_active (das_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending requests as a set, repeat timing from counts of held ticks
  bit m_busy;
  int m_op;
  bit m_das;
  int held_ticks, soft_ticks, grav_ticks;
  bit pend[7];
  bit prev[5];
  int prio[6] = '{OP_HARD, OP_ROT, OP_LEFT, OP_RIGHT, OP_SOFT, OP_GRAV};

  function automatic void m_reset();
    m_busy = 0; m_op = 0; m_das = 0;
    held_ticks = 0; soft_ticks = 0; grav_ticks = 0;
    for (int i = 0; i < 7; i++) pend[i] = 0;
    for (int i = 0; i < 5; i++) prev[i] = 0;
  endfunction

  task automatic model_update();
    bit k[5];
    bit r[5];
    bit ev[7];
    bit np[7];
    int per;
    bit ready;
    ready = cmd_bus.cmd_ready;
    k = '{key_left, key_right, key_down, key_rotate, key_drop};
    for (int i = 0; i < 5; i++) begin
      r[i] = k[i] && !prev[i];
      prev[i] = k[i];
    end
    for (int i = 0; i < 7; i++) ev[i] = 0;
    if (enable) begin
      ev[OP_LEFT] = r[0]; ev[OP_RIGHT] = r[1]; ev[OP_SOFT] = r[2];
      ev[OP_ROT] = r[3]; ev[OP_HARD] = r[4];
      if (r[0] || r[1] || (k[0] == k[1])) begin
        held_ticks = 0; m_das = 0;
      end else if (tick_game) begin
        held_ticks++;
        if (held_ticks >= DAS_DELAY && (held_ticks - DAS_DELAY) % DAS_RATE == 0)
          ev[k[0] ? OP_LEFT : OP_RIGHT] = 1;
        m_das = (held_ticks >= DAS_DELAY);
      end
      if (r[2] || !k[2]) soft_ticks = 0;
      else if (tick_game) begin
        soft_ticks++;
        if (soft_ticks % SOFT_RATE == 0) ev[OP_SOFT] = 1;
      end
      if (tick_game) begin
        per = 48 - 3 * int'(level);
        if (per < 2) per = 2;
        grav_ticks++;
        if (grav_ticks >= per) begin
          grav_ticks = 0; ev[OP_GRAV] = 1;
        end
      end
    end else begin
      held_ticks = 0; m_das = 0; soft_ticks = 0; grav_ticks = 0;
    end
    np = pend;
    if (m_busy && ready) begin
      np[m_op] = 0;
      if (m_op == OP_SOFT || m_op == OP_HARD) grav_ticks = 0;
      if (m_op == OP_HARD) begin np[OP_SOFT] = 0; np[OP_GRAV] = 0; end
    end
    for (int o = 1; o < 7; o++) np[o] = (np[o] || ev[o]) && enable;
    if (m_busy) begin
      if (ready) begin m_busy = 0; m_op = 0; end
    end else if (enable) begin
      for (int i = 0; i < 6; i++)
        if (!m_busy && pend[prio[i]]) begin m_busy = 1; m_op = prio[i]; end
    end
    pend = np;
  endtask

  int log_op[$];
  int log_tick[$];
  int tick_n = 0;
  int valid_cycles = 0;
  bit prev_valid = 0;

  task automatic do_cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("model_valid", int'(cmd_bus.cmd_valid), int'(m_busy));
    check("model_op", int'(cmd_bus.cmd_op), m_op);
    check("model_das", int'(das_active), int'(m_das));
    if (cmd_bus.cmd_valid) valid_cycles++;
    if (cmd_bus.cmd_valid && !prev_valid) begin
      log_op.push_back(int'(cmd_bus.cmd_op));
      log_tick.push_back(tick_n);
    end
    prev_valid = cmd_bus.cmd_valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic tick_once();
    tick_game = 1'b1;
    tick_n++;
    do_cycle();
    tick_game = 1'b0;
  endtask

  task automatic clear_log();
    log_op.delete(); log_tick.delete(); valid_cycles = 0; tick_n = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_game = 0; enable = 0; level = 0; cmd_bus.cmd_ready = 0;
    key_left = 0; key_right = 0; key_down = 0; key_rotate = 0; key_drop = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_valid", int'(cmd_bus.cmd_valid), 0);
    check("reset_op", int'(cmd_bus.cmd_op), 0);
    check("reset_das", int'(das_active), 0);
    rst_n = 1'b1;
    prev_valid = 0;
    clear_log();
  endtask

  typedef struct {
    bit tick; bit down; bit rot; bit drop; bit ready;
    bit exp_valid; int exp_op;
  } vec_t;
  vec_t tbl[13];

  int exp_grav[2] = '{48, 96};
  int exp_left[5] = '{0, 10, 13, 16, 19};
  int bad;

  initial begin
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, OP_SOFT};
    tbl[2]  = '{1, 0, 0, 0, 0, 1, OP_SOFT};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, OP_SOFT};
    tbl[4]  = '{1, 0, 0, 0, 0, 1, OP_SOFT};
    tbl[5]  = '{0, 0, 1, 1, 0, 1, OP_SOFT};
    tbl[6]  = '{0, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 1, 1, OP_HARD};
    tbl[8]  = '{0, 0, 1, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 1, 1, OP_ROT};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 0, 0};

    // Gravity at level 0 with cmd_ready tied high
    do_reset();
    enable = 1; cmd_bus.cmd_ready = 1;
    for (int t = 0; t < 100; t++) begin idle(3); tick_once(); end
    idle(2);
    check("grav_count", log_op.size(), 2);
    check("grav_valid_cycles", valid_cycles, 2);
    for (int i = 0; i < 2; i++) begin
      check("grav_tick", (i < log_tick.size()) ? log_tick[i] : -1, exp_grav[i]);
      check("grav_op", (i < log_op.size()) ? log_op[i] : -1, OP_GRAV);
    end

    // Held left key: press, then DAS repeats
    do_reset();
    enable = 1; cmd_bus.cmd_ready = 1;
    idle(1);
    key_left = 1;
    idle(1);
    for (int t = 0; t < 20; t++) begin
      idle(3); tick_once();
      check("das_ramp", int'(das_active), (tick_n >= DAS_DELAY) ? 1 : 0);
    end
    key_left = 0;
    do_cycle();
    check("das_release", int'(das_active), 0);
    check("left_count", log_op.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("left_tick", (i < log_tick.size()) ? log_tick[i] : -1, exp_left[i]);
      check("left_op", (i < log_op.size()) ? log_op[i] : -1, OP_LEFT);
    end

    // Table: SOFT held off, then HARD/ROT together, HARD drops pending gravity
    do_reset();
    enable = 1; level = 15;
    for (int i = 0; i < 13; i++) begin
      tick_game = tbl[i].tick; key_down = tbl[i].down;
      key_rotate = tbl[i].rot; key_drop = tbl[i].drop; cmd_bus.cmd_ready = tbl[i].ready;
      do_cycle();
      check($sformatf("tbl%0d_valid", i), int'(cmd_bus.cmd_valid), int'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_op", i), int'(cmd_bus.cmd_op), tbl[i].exp_op);
    end
    tick_game = 0;

    // Coalescing: three gravity periods with cmd_ready low give one command
    do_reset();
    enable = 1; level = 15;
    bad = 0;
    for (int t = 0; t < 9; t++) begin
      for (int c = 0; c < 4; c++) begin
        tick_game = (c == 3);
        if (c == 3) tick_n++;
        do_cycle();
        if (cmd_bus.cmd_valid && cmd_bus.cmd_op != 3'(OP_GRAV)) bad++;
      end
    end
    tick_game = 0;
    check("coal_stable", bad, 0);
    check("coal_valid", int'(cmd_bus.cmd_valid), 1);
    cmd_bus.cmd_ready = 1;
    idle(3);
    check("coal_count", log_op.size(), 1);
    check("coal_after", int'(cmd_bus.cmd_valid), 0);

    // Left and right together: one of each, no auto-repeat
    do_reset();
    enable = 1; cmd_bus.cmd_ready = 1;
    idle(1);
    key_left = 1; key_right = 1;
    idle(1);
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      idle(3); tick_once();
      if (das_active) bad++;
    end
    key_left = 0; key_right = 0;
    idle(2);
    check("lr_das", bad, 0);
    check("lr_count", log_op.size(), 2);
    check("lr_first", (log_op.size() > 0) ? log_op[0] : -1, OP_LEFT);
    check("lr_second", (log_op.size() > 1) ? log_op[1] : -1, OP_RIGHT);

    // Dropping enable during ISSUE, then asynchronous reset mid-handshake
    do_reset();
    enable = 1; level = 15;
    for (int t = 0; t < 3; t++) begin idle(3); tick_once(); end
    idle(1);
    check("en_offer", int'(cmd_bus.cmd_op), OP_GRAV);
    enable = 0;
    idle(3);
    check("en_hold_valid", int'(cmd_bus.cmd_valid), 1);
    check("en_hold_op", int'(cmd_bus.cmd_op), OP_GRAV);
    cmd_bus.cmd_ready = 1;
    do_cycle();
    check("en_accept", int'(cmd_bus.cmd_valid), 0);
    log_op.delete();
    key_rotate = 1;
    for (int t = 0; t < 6; t++) begin idle(1); tick_once(); end
    check("en_quiet", log_op.size(), 0);
    enable = 1;
    idle(3);
    check("en_no_stale_edge", log_op.size(), 0);
    key_rotate = 0;
    cmd_bus.cmd_ready = 0;
    idle(1);
    key_drop = 1;
    idle(2);
    check("rst_pre_valid", int'(cmd_bus.cmd_valid), 1);
    check("rst_pre_op", int'(cmd_bus.cmd_op), OP_HARD);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_valid", int'(cmd_bus.cmd_valid), 0);
    check("async_rst_op", int'(cmd_bus.cmd_op), 0);
    m_reset();

    // Randomized traffic against the reference model
    do_reset();
    enable = 1; level = 12;
    for (int n = 0; n < 3000; n++) begin
      tick_game = ($urandom_range(0, 3) == 0);
      cmd_bus.cmd_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) key_left = ~key_left;
      if ($urandom_range(0, 11) == 0) key_right = ~key_right;
      if ($urandom_range(0, 15) == 0) key_down = ~key_down;
      if ($urandom_range(0, 15) == 0) key_rotate = ~key_rotate;
      if ($urandom_range(0, 23) == 0) key_drop = ~key_drop;
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
